// File: rtl/icache_line_unpacker.sv
// icache_line_unpacker: holds one I-cache line and issues its instructions to
// decode one per cycle, from the fetch-PC slot to the end of the line.
module icache_line_unpacker #(
  parameter int LINE_OFFSET     = 4,
  parameter int XLEN            = 32,
  parameter int ILEN            = 32,
  parameter int EXCEPT_TYPE_LEN = 4
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   flush_i,
  input  logic                                   line_valid_i,
  output logic                                   line_ready_o,
  input  logic [XLEN+(1<<LINE_OFFSET)*ILEN-1:0]  line_i,
  output logic                                   instr_valid_o,
  input  logic                                   instr_ready_i,
  output logic [ILEN-1:0]                        instr_o,
  output logic [XLEN-1:0]                        pc_o,
  output logic                                   except_o,
  output logic [EXCEPT_TYPE_LEN-1:0]             except_code_o
);

  localparam int NINSTR = 1 << LINE_OFFSET;
  localparam logic [ILEN-1:0] NOP = ILEN'('h13);
  localparam logic [EXCEPT_TYPE_LEN-1:0] E_I_ADDR_MISALIGNED = '0;

  typedef enum logic {S_EMPTY, S_ISSUE} state_t;

  state_t                 r_state;
  logic [LINE_OFFSET-1:0] r_idx;
  logic [XLEN-1:0]        r_pc;
  logic [ILEN-1:0]        r_line [NINSTR];
  logic                   r_misal;

  logic [XLEN-1:0]        w_in_pc;
  logic                   w_last;
  logic                   w_issue_hs;
  logic                   w_accept;

  assign w_in_pc = line_i[NINSTR*ILEN +: XLEN];

  // A misaligned line issues only its exception entry, so it is always the last.
  assign w_last     = r_misal | (r_idx == LINE_OFFSET'(NINSTR-1));
  assign w_issue_hs = instr_valid_o & instr_ready_i;

  // Next line can be taken while the last entry of the current one retires,
  // which makes instr_ready_i -> line_ready_o a deliberate combinational path.
  assign line_ready_o = !flush_i &
                        ((r_state == S_EMPTY) | ((r_state == S_ISSUE) & instr_ready_i & w_last));
  assign w_accept     = line_valid_i & line_ready_o;

  // Issue-side outputs are decoded straight from the held state so they stay
  // stable for as long as decode stalls.
  always_comb begin
    instr_valid_o = (r_state == S_ISSUE);
    except_o      = (r_state == S_ISSUE) & r_misal;
    except_code_o = E_I_ADDR_MISALIGNED;
    instr_o       = NOP;
    pc_o          = {r_pc[XLEN-1:LINE_OFFSET+2], r_idx, 2'b00};
    if (r_misal) begin
      pc_o = r_pc;
    end else if (r_state == S_ISSUE) begin
      instr_o = r_line[r_idx];
    end
  end

  // Line capture, slot advance and state sequencing; flush overrides everything.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_EMPTY;
      r_idx   <= '0;
      r_pc    <= '0;
      r_misal <= 1'b0;
      for (int k = 0; k < NINSTR; k++) r_line[k] <= '0;
    end else if (flush_i) begin
      r_state <= S_EMPTY;
      r_idx   <= '0;
      r_misal <= 1'b0;
    end else if (w_accept) begin
      r_state <= S_ISSUE;
      r_pc    <= w_in_pc;
      r_idx   <= w_in_pc[LINE_OFFSET+1:2];
      r_misal <= (w_in_pc[1:0] != 2'b00);
      for (int k = 0; k < NINSTR; k++) r_line[k] <= line_i[k*ILEN +: ILEN];
    end else if (w_issue_hs) begin
      if (w_last) r_state <= S_EMPTY;
      else        r_idx   <= r_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_icache_line_unpacker.sv
// Testbench for icache_line_unpacker: directed scenarios plus random traffic,
// checked against a queue of expected issue entries built from each line.
module tb_icache_line_unpacker;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam int NI   = 16;
  localparam int LW   = XLEN + NI*ILEN;
  localparam logic [31:0] NOP = 32'h13;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           flush;
  logic           line_valid;
  logic           line_ready;
  logic [LW-1:0]  line_data;
  logic           instr_valid;
  logic           instr_ready;
  logic [31:0]    instr;
  logic [31:0]    pc;
  logic           exc;
  logic [3:0]     exc_code;

  icache_line_unpacker dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .flush_i       (flush),
    .line_valid_i  (line_valid),
    .line_ready_o  (line_ready),
    .line_i        (line_data),
    .instr_valid_o (instr_valid),
    .instr_ready_i (instr_ready),
    .instr_o       (instr),
    .pc_o          (pc),
    .except_o      (exc),
    .except_code_o (exc_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic        exc;
  } ent_t;

  ent_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  logic        offer;
  logic        rdy;
  logic        fl;
  logic [31:0] off_pc;
  logic [31:0] off_ins [NI];
  logic        accepted;
  int          hs_count;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [LW-1:0] pack_line();
    logic [LW-1:0] v;
    v = '0;
    for (int k = 0; k < NI; k++) v[k*ILEN +: ILEN] = off_ins[k];
    v[NI*ILEN +: XLEN] = off_pc;
    return v;
  endfunction

  // Expected issue sequence of a line, derived from its fetch PC alone.
  task automatic push_line();
    ent_t e;
    if (off_pc[1:0] != 2'b00) begin
      e.ins = NOP; e.pc = off_pc; e.exc = 1'b1;
      exp_q.push_back(e);
    end else begin
      for (int k = int'(off_pc[5:2]); k < NI; k++) begin
        e.ins = off_ins[k];
        e.pc  = (off_pc & 32'hFFFF_FFC0) + 32'(4*k);
        e.exc = 1'b0;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic set_line(input logic [31:0] p, input bit counting);
    off_pc = p;
    for (int k = 0; k < NI; k++) off_ins[k] = counting ? 32'(k+1) : $urandom;
  endtask

  task automatic cycle();
    logic exp_lr;
    int   sz;
    line_valid  = offer;
    line_data   = pack_line();
    instr_ready = rdy;
    flush       = fl;
    accepted    = 1'b0;
    @(negedge clk);
    sz = exp_q.size();
    check_eq("instr_valid", 64'(instr_valid), 64'(sz > 0));
    if (sz > 0 && instr_valid) begin
      check_eq("instr", 64'(instr), 64'(exp_q[0].ins));
      check_eq("pc", 64'(pc), 64'(exp_q[0].pc));
      check_eq("except", 64'(exc), 64'(exp_q[0].exc));
      if (exp_q[0].exc) check_eq("except_code", 64'(exc_code), 64'h0);
    end
    exp_lr = !fl && (sz == 0 || (sz == 1 && rdy));
    check_eq("line_ready", 64'(line_ready), 64'(exp_lr));
    if (fl) begin
      exp_q.delete();
    end else begin
      if (sz > 0 && rdy) begin
        void'(exp_q.pop_front());
        hs_count++;
      end
      if (offer && exp_lr) begin
        push_line();
        accepted = 1'b1;
        offer    = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_empty(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || offer) && n < budget) begin
      cycle();
      n++;
    end
    check_eq("drain_timeout", 64'(n < budget), 64'h1);
  endtask

  int stall_pat [4] = '{1, 0, 0, 1};

  initial begin
    rst_n = 1'b0; flush = 1'b0; line_valid = 1'b0; instr_ready = 1'b0;
    line_data = '0; offer = 1'b0; rdy = 1'b0; fl = 1'b0; hs_count = 0;
    off_pc = '0;
    for (int k = 0; k < NI; k++) off_ins[k] = '0;
    #12;
    check_eq("rst_valid", 64'(instr_valid), 64'h0);
    check_eq("rst_line_ready", 64'(line_ready), 64'h1);
    check_eq("rst_except", 64'(exc), 64'h0);
    check_eq("rst_instr", 64'(instr), 64'(NOP));
    check_eq("rst_pc", 64'(pc), 64'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Full line from slot 0, decode always ready
    set_line(32'h1000, 1'b1); offer = 1'b1; rdy = 1'b1;
    hs_count = 0;
    run_until_empty(40);
    check_eq("full_line_issues", 64'(hs_count), 64'd16);

    // Fetch PC in slot 14: two entries
    set_line(32'h2038, 1'b0); offer = 1'b1; hs_count = 0;
    run_until_empty(20);
    check_eq("slot14_issues", 64'(hs_count), 64'd2);

    // Back-to-back lines, second one offered while the first is issuing
    set_line(32'h1000, 1'b1); offer = 1'b1;
    while (!accepted) cycle();
    set_line(32'h1040, 1'b0); offer = 1'b1; hs_count = 0;
    run_until_empty(60);
    check_eq("b2b_no_gap", 64'(hs_count), 64'd32);

    // Stall pattern on decode ready
    set_line(32'h1000, 1'b0); offer = 1'b1; rdy = 1'b1;
    while (!accepted) cycle();
    for (int i = 0; i < 4; i++) begin
      rdy = stall_pat[i][0];
      cycle();
    end
    rdy = 1'b1;
    run_until_empty(40);

    // Flush at slot 5 with a new line pending
    set_line(32'h1000, 1'b0); offer = 1'b1;
    while (!accepted) cycle();
    for (int i = 0; i < 5; i++) cycle();
    set_line(32'h5000, 1'b0); offer = 1'b1; fl = 1'b1;
    cycle();
    check_eq("flush_no_accept", 64'(accepted), 64'h0);
    fl = 1'b0; offer = 1'b0;
    cycle();

    // Misaligned fetch PC
    set_line(32'h3002, 1'b0); offer = 1'b1; hs_count = 0;
    run_until_empty(10);
    check_eq("misal_issues", 64'(hs_count), 64'd1);

    // Asynchronous reset in the middle of a line
    set_line(32'h1000, 1'b0); offer = 1'b1;
    while (!accepted) cycle();
    for (int i = 0; i < 7; i++) cycle();
    check_eq("pre_reset_valid", 64'(instr_valid), 64'h1);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_valid", 64'(instr_valid), 64'h0);
    check_eq("async_rst_line_ready", 64'(line_ready), 64'h1);
    exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    cycle();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if (!offer && $urandom_range(0, 3) == 0) begin
        logic [31:0] p;
        p = $urandom & 32'hFFFF_FFC0;
        case ($urandom_range(0, 3))
          0:       p = p | 32'($urandom_range(0, 63));
          default: p = p | (32'($urandom_range(10, 15)) << 2);
        endcase
        set_line(p, 1'b0);
        offer = 1'b1;
      end
      rdy = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 49) == 0);
      cycle();
    end
    fl = 1'b0; rdy = 1'b1; offer = 1'b0;
    run_until_empty(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
